// File: rtl/synth_pkg.sv
// Shared types and defaults for the oscillator voice scheduler.
package synth_pkg;

  localparam int DEF_NUM_VOICES = 4;
  localparam int DEF_SAMPLE_W   = 16;

  // Frame sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SCAN,
    ST_REQ,
    ST_ACC,
    ST_DONE
  } state_t;

  // Per-voice configuration as written by the host.
  typedef struct packed {
    logic [31:0] freq;
    logic        gate;
  } voice_cfg_t;

endpackage

// File: rtl/voice_regfile.sv
// Voice configuration storage. The host writes the staging copy at any time.
// The sequencer snapshots staging into the shadow copy once per frame, so a
// frame always runs on a consistent configuration. note_on flags voices whose
// gate rises in that snapshot so their phase can be restarted.
import synth_pkg::*;

module voice_regfile #(
  parameter  int NUM_VOICES = DEF_NUM_VOICES,
  localparam int VW         = $clog2(NUM_VOICES)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              cfg_we,
  input  logic [VW-1:0]                     cfg_voice,
  input  logic [31:0]                       cfg_freq,
  input  logic                              cfg_gate,
  input  logic                              load,
  output voice_cfg_t [NUM_VOICES-1:0]       shadow,
  output logic [NUM_VOICES-1:0]             note_on
);

  voice_cfg_t [NUM_VOICES-1:0] staging;

  // Host writes land in staging; the last write before a snapshot wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      staging <= '0;
    end else if (cfg_we) begin
      staging[cfg_voice] <= '{freq: cfg_freq, gate: cfg_gate};
    end
  end

  // Snapshot all voices at frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
    end else if (load) begin
      shadow <= staging;
    end
  end

  // Gate rising between the previous snapshot and the one being taken now.
  always_comb begin
    note_on = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      note_on[v] = load & staging[v].gate & ~shadow[v].gate;
    end
  end

endmodule

// File: rtl/osc_voice_scheduler.sv
// Time-multiplexes one sine lookup datapath across NUM_VOICES oscillators.
// Each Syn_tick starts a frame: snapshot the voice config, walk the slots,
// fetch one sample per gated voice, advance its phase and sum into Mix_out.
//
// Lookup handshake: Lut_req is high for the whole REQ state and Lut_phase is
// held constant while it is high. The datapath answers with a single-cycle
// Lut_ack, and Lut_data is taken in that same cycle; the request drops on the
// following cycle. Lut_ack outside a request is ignored and there is no
// timeout, so a datapath that never acknowledges stalls the frame.
import synth_pkg::*;

module osc_voice_scheduler #(
  parameter  int NUM_VOICES = DEF_NUM_VOICES,
  parameter  int SAMPLE_W   = DEF_SAMPLE_W,
  parameter  int MIX_W      = SAMPLE_W + $clog2(NUM_VOICES),
  localparam int VW         = $clog2(NUM_VOICES)
) (
  input  logic                Sys_clk,
  input  logic                Sys_rst_n,
  input  logic                Syn_tick,
  input  logic                Cfg_we,
  input  logic [VW-1:0]       Cfg_voice,
  input  logic [31:0]         Cfg_freq,
  input  logic                Cfg_gate,
  output logic                Lut_req,
  output logic [31:0]         Lut_phase,
  input  logic                Lut_ack,
  input  logic [SAMPLE_W-1:0] Lut_data,
  output logic [MIX_W-1:0]    Mix_out,
  output logic                Mix_valid,
  output logic                Busy,
  output logic                Overrun,
  output state_t              dbg_state
);

  state_t                      state;
  state_t                      next_state;
  logic [VW-1:0]               idx;
  logic                        is_last;
  logic [MIX_W-1:0]            acc;
  logic [MIX_W-1:0]            acc_sum;
  logic [SAMPLE_W-1:0]         lut_data_q;
  logic [31:0]                 phase [NUM_VOICES];
  logic [MIX_W-1:0]            mix_q;
  logic                        overrun_q;
  voice_cfg_t [NUM_VOICES-1:0] shadow;
  logic [NUM_VOICES-1:0]       note_on;
  logic                        load;

  assign load    = (state == ST_LOAD);
  assign is_last = (idx == VW'(NUM_VOICES - 1));
  // Sample is sign-extended; MIX_W leaves room for every voice at full scale.
  assign acc_sum = acc + {{(MIX_W - SAMPLE_W){lut_data_q[SAMPLE_W-1]}}, lut_data_q};

  voice_regfile #(
    .NUM_VOICES (NUM_VOICES)
  ) u_regfile (
    .clk       (Sys_clk),
    .rst_n     (Sys_rst_n),
    .cfg_we    (Cfg_we),
    .cfg_voice (Cfg_voice),
    .cfg_freq  (Cfg_freq),
    .cfg_gate  (Cfg_gate),
    .load      (load),
    .shadow    (shadow),
    .note_on   (note_on)
  );

  // State register.
  always_ff @(posedge Sys_clk or negedge Sys_rst_n) begin
    if (!Sys_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic for the frame walk.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (Syn_tick) next_state = ST_LOAD;
      ST_LOAD: next_state = ST_SCAN;
      ST_SCAN: begin
        if (shadow[idx].gate) next_state = ST_REQ;
        else if (is_last)     next_state = ST_DONE;
        else                  next_state = ST_SCAN;
      end
      ST_REQ:  if (Lut_ack) next_state = ST_ACC;
      ST_ACC:  next_state = is_last ? ST_DONE : ST_SCAN;
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Voice slot pointer: restarts at LOAD, steps after each slot is finished.
  always_ff @(posedge Sys_clk or negedge Sys_rst_n) begin
    if (!Sys_rst_n) begin
      idx <= '0;
    end else if (state == ST_LOAD) begin
      idx <= '0;
    end else if ((state == ST_SCAN && !shadow[idx].gate && !is_last) ||
                 (state == ST_ACC && !is_last)) begin
      idx <= idx + 1'b1;
    end
  end

  // Sample capture on ack and running accumulation of the frame mix.
  always_ff @(posedge Sys_clk or negedge Sys_rst_n) begin
    if (!Sys_rst_n) begin
      lut_data_q <= '0;
      acc        <= '0;
    end else begin
      if (state == ST_REQ && Lut_ack) lut_data_q <= Lut_data;
      if (state == ST_LOAD)           acc <= '0;
      else if (state == ST_ACC)       acc <= acc_sum;
    end
  end

  // Mix output is loaded on the way into DONE so it is valid alongside Mix_valid.
  always_ff @(posedge Sys_clk or negedge Sys_rst_n) begin
    if (!Sys_rst_n) begin
      mix_q <= '0;
    end else if (next_state == ST_DONE) begin
      mix_q <= (state == ST_ACC) ? acc_sum : acc;
    end
  end

  // Phase accumulators: restart on note-on, advance after each fetch (wraps mod 2^32).
  always_ff @(posedge Sys_clk or negedge Sys_rst_n) begin
    if (!Sys_rst_n) begin
      for (int v = 0; v < NUM_VOICES; v++) phase[v] <= '0;
    end else if (state == ST_LOAD) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (note_on[v]) phase[v] <= '0;
      end
    end else if (state == ST_ACC) begin
      phase[idx] <= phase[idx] + shadow[idx].freq;
    end
  end

  // A tick that arrives mid-frame is dropped and flagged one cycle later.
  always_ff @(posedge Sys_clk or negedge Sys_rst_n) begin
    if (!Sys_rst_n) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= Syn_tick && (state != ST_IDLE);
    end
  end

  assign Lut_req   = (state == ST_REQ);
  assign Lut_phase = Lut_req ? phase[idx] : 32'd0;
  assign Mix_out   = mix_q;
  assign Mix_valid = (state == ST_DONE);
  assign Busy      = (state != ST_IDLE);
  assign Overrun   = overrun_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_osc_voice_scheduler.sv
// Bench for osc_voice_scheduler: directed frames with pinned literal values,
// then randomized ticks/config writes against a frame-level reference model.
`timescale 1ns/1ps
module tb_osc_voice_scheduler;
  import synth_pkg::*;

  localparam int NV = 4;
  localparam int SW = 16;
  localparam int MW = 18;
  localparam int VW = 2;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          syn_tick  = 1'b0;
  logic          cfg_we    = 1'b0;
  logic [VW-1:0] cfg_voice = '0;
  logic [31:0]   cfg_freq  = '0;
  logic          cfg_gate  = 1'b0;
  logic          lut_req;
  logic [31:0]   lut_phase;
  logic          lut_ack   = 1'b0;
  logic [SW-1:0] lut_data  = '0;
  logic [MW-1:0] mix_out;
  logic          mix_valid;
  logic          busy;
  logic          overrun;
  state_t        dbg_state;

  osc_voice_scheduler #(.NUM_VOICES(NV), .SAMPLE_W(SW), .MIX_W(MW)) dut (
    .Sys_clk   (clk),
    .Sys_rst_n (rst_n),
    .Syn_tick  (syn_tick),
    .Cfg_we    (cfg_we),
    .Cfg_voice (cfg_voice),
    .Cfg_freq  (cfg_freq),
    .Cfg_gate  (cfg_gate),
    .Lut_req   (lut_req),
    .Lut_phase (lut_phase),
    .Lut_ack   (lut_ack),
    .Lut_data  (lut_data),
    .Mix_out   (mix_out),
    .Mix_valid (mix_valid),
    .Busy      (busy),
    .Overrun   (overrun),
    .dbg_state (dbg_state)
  );

  // ---------------- directed pins (written by stimulus only) ----------------
  logic        pin_en   = 1'b0;
  logic        hold_ack = 1'b0;
  logic        fin_req  = 1'b0;
  logic [31:0] pin_phase [$];
  int          pin_mix   [$];
  int          resp_q    [$];

  // ---------------- lookup responder ----------------
  int resp_rd  = 0;
  int wait_cnt = 0;
  int dly      = 0;
  bit req_seen = 0;

  always begin
    @(posedge clk); #1;
    if (!rst_n) begin
      lut_ack  = 1'b0;
      req_seen = 0;
    end else begin
      lut_ack = 1'b0;
      if (lut_req && !hold_ack) begin
        if (!req_seen) begin
          req_seen = 1;
          wait_cnt = 0;
          dly      = pin_en ? 1 : $urandom_range(0, 3);
        end else begin
          wait_cnt++;
        end
        if (wait_cnt == dly) begin
          lut_ack = 1'b1;
          if (pin_en && resp_rd < resp_q.size()) begin
            lut_data = resp_q[resp_rd][SW-1:0];
            resp_rd++;
          end else begin
            lut_data = SW'($urandom);
          end
          req_seen = 0;
        end
      end else if (!lut_req) begin
        req_seen = 0;
        lut_ack  = ($urandom_range(0, 7) == 0);
        lut_data = SW'($urandom);
      end
    end
  end

  // ---------------- reference model + scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [31:0]   stg_f [NV];
  logic          stg_g [NV];
  logic [31:0]   shd_f [NV];
  logic          shd_g [NV];
  logic [31:0]   ph_m  [NV];
  logic [VW-1:0] exp_q [$];

  bit          in_frame, was_in, exp_valid, ovr_exp, load_pending, req_active, fin_done;
  int          frame_start, frame_end, served, n_gated, exp_mix, req_len;
  int          ph_rd, mix_rd, tmp_i;
  logic [31:0] req_ph;
  logic [MW-1:0] exp_mix_v;
  logic [VW-1:0] v_done;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always begin
    @(negedge clk or negedge rst_n);
    if (!rst_n) begin
      #1;
      check("rst_lut_req",   lut_req,   1'b0);
      check("rst_lut_phase", lut_phase, 32'd0);
      check("rst_busy",      busy,      1'b0);
      check("rst_mix_valid", mix_valid, 1'b0);
      check("rst_mix_out",   mix_out,   '0);
      check("rst_overrun",   overrun,   1'b0);
      for (int v = 0; v < NV; v++) begin
        stg_f[v] = '0; stg_g[v] = 1'b0; shd_f[v] = '0; shd_g[v] = 1'b0; ph_m[v] = '0;
      end
      exp_q.delete();
      in_frame = 0; ovr_exp = 0; load_pending = 0; req_active = 0;
    end else begin
      cyc++;
      // outputs of this cycle
      exp_valid = in_frame && (served == n_gated) && (cyc == frame_end);
      check("busy",      busy,      in_frame);
      check("mix_valid", mix_valid, exp_valid);
      check("overrun",   overrun,   ovr_exp);
      if (exp_valid) begin
        exp_mix_v = exp_mix[MW-1:0];
        check("mix_out", mix_out, exp_mix_v);
      end
      if (mix_valid && pin_en && mix_rd < pin_mix.size()) begin
        tmp_i = pin_mix[mix_rd];
        exp_mix_v = tmp_i[MW-1:0];
        check("pin_mix", mix_out, exp_mix_v);
        mix_rd++;
      end
      // lookup requests
      if (lut_req) begin
        if (!req_active) begin
          req_active = 1;
          req_len    = 0;
          req_ph     = lut_phase;
          if (pin_en && ph_rd < pin_phase.size()) begin
            check("pin_phase", lut_phase, pin_phase[ph_rd]);
            ph_rd++;
          end
          if (!in_frame || exp_q.size() == 0) check("spurious_req", lut_req, 1'b0);
          else                                check("req_phase", lut_phase, ph_m[exp_q[0]]);
        end else begin
          check("phase_stable", lut_phase, req_ph);
        end
        req_len++;
        if (lut_ack) begin
          if (exp_q.size() > 0) begin
            v_done = exp_q.pop_front();
            exp_mix += int'($signed(lut_data));
            ph_m[v_done] = ph_m[v_done] + shd_f[v_done];
            served++;
            frame_end += req_len + 1;
          end
          req_active = 0;
        end
      end else begin
        req_active = 0;
      end
      // frame bookkeeping
      was_in  = in_frame;
      ovr_exp = syn_tick && was_in;
      if (exp_valid) in_frame = 0;
      if (was_in && cyc > frame_start + 300) begin
        check("frame_timeout", busy, 1'b0);
        in_frame = 0;
      end
      if (load_pending) begin
        load_pending = 0;
        exp_q.delete();
        for (int v = 0; v < NV; v++) begin
          if (stg_g[v] && !shd_g[v]) ph_m[v] = '0;
          shd_g[v] = stg_g[v];
          shd_f[v] = stg_f[v];
          if (shd_g[v]) exp_q.push_back(VW'(v));
        end
        n_gated = exp_q.size();
      end
      if (syn_tick && !was_in) begin
        in_frame     = 1;
        frame_start  = cyc;
        frame_end    = cyc + 2 + NV;
        served       = 0;
        n_gated      = -1;
        exp_mix      = 0;
        load_pending = 1;
      end
      if (cfg_we) begin
        stg_f[cfg_voice] = cfg_freq;
        stg_g[cfg_voice] = cfg_gate;
      end
      if (fin_req && !fin_done) begin
        fin_done = 1;
        check("pins_phase_seen", ph_rd,  pin_phase.size());
        check("pins_mix_seen",   mix_rd, pin_mix.size());
      end
    end
  end

  // ---------------- driver tasks (start and end at posedge+1) ----------------
  task automatic cfg_write(input int v, input logic [31:0] f, input logic g);
    cfg_we = 1'b1; cfg_voice = VW'(v); cfg_freq = f; cfg_gate = g;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic tick();
    syn_tick = 1'b1;
    @(posedge clk); #1;
    syn_tick = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (!busy) break;
    end
  endtask

  task automatic wait_req();
    for (int i = 0; i < 50; i++) begin
      if (lut_req) break;
      @(posedge clk); #1;
    end
  endtask

  task automatic frame(input logic [31:0] ph, input int data);
    pin_phase.push_back(ph);
    resp_q.push_back(data);
    pin_mix.push_back(data);
    tick();
    wait_idle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    pin_en = 1'b1;

    // single voice, phase steps by freq each frame
    cfg_write(0, 32'd1000, 1'b1);
    frame(32'd0,    11);
    frame(32'd1000, 22);
    frame(32'd2000, 33);
    frame(32'd3000, 44);

    // all voices off: no request, zero mix
    cfg_write(0, 32'd1000, 1'b0);
    pin_mix.push_back(0);
    tick(); wait_idle();

    // all voices gated; voice 0 off->on restarts its phase
    for (int v = 0; v < NV; v++) cfg_write(v, 32'(10 * (v + 1)), 1'b1);
    foreach (resp_q[i]) begin end
    for (int v = 0; v < NV; v++) pin_phase.push_back(32'd0);
    resp_q.push_back(100); resp_q.push_back(-200); resp_q.push_back(300); resp_q.push_back(32767);
    pin_mix.push_back(32967);
    tick(); wait_idle();
    for (int v = 0; v < NV; v++) begin
      pin_phase.push_back(32'(10 * (v + 1)));
      resp_q.push_back(v + 1);
    end
    pin_mix.push_back(10);
    tick(); wait_idle();

    // 32-bit phase wrap on voice 1
    for (int v = 0; v < NV; v++) cfg_write(v, 32'd0, 1'b0);
    pin_mix.push_back(0);
    tick(); wait_idle();
    cfg_write(1, 32'hFFFF_FF00, 1'b1);
    frame(32'h0000_0000, 5);
    frame(32'hFFFF_FF00, 6);
    frame(32'hFFFF_FE00, 7);

    // overrun: second tick two cycles after the first; config write during REQ
    pin_phase.push_back(32'hFFFF_FD00); resp_q.push_back(9); pin_mix.push_back(9);
    tick();
    @(posedge clk); #1;
    tick();
    wait_req();
    cfg_write(1, 32'h10, 1'b1);
    wait_idle();
    frame(32'hFFFF_FC00, 10);
    frame(32'hFFFF_FC10, 11);

    // reset while a request is outstanding
    pin_phase.push_back(32'hFFFF_FC20);
    hold_ack = 1'b1;
    tick();
    wait_req();
    @(posedge clk); #3;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    hold_ack = 1'b0;
    cfg_write(1, 32'd77, 1'b1);
    frame(32'd0, 12);

    // randomized traffic
    pin_en = 1'b0;
    for (int i = 0; i < 800; i++) begin
      syn_tick  = ($urandom_range(0, 15) == 0);
      cfg_we    = ($urandom_range(0, 5) == 0);
      cfg_voice = VW'($urandom_range(0, NV - 1));
      cfg_freq  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      cfg_gate  = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
    end
    syn_tick = 1'b0;
    cfg_we   = 1'b0;
    wait_idle();

    fin_req = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
